// File: rtl/st7789_pkg.sv
// st7789_pkg: ST7789 command codes and decoder state for the panel-side receiver.
package st7789_pkg;

    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CASET,
        S_RASET,
        S_RAMWR,
        S_SKIP
    } dec_state_t;

    // Power/display commands carry no parameters and return the decoder to IDLE.
    function automatic logic is_ctrl_cmd(input logic [7:0] b);
        return b inside {CMD_SLPIN, CMD_SLPOUT, CMD_DISPOFF, CMD_DISPON};
    endfunction

endpackage

// File: rtl/st7789_rx_if.sv
// st7789_rx_if: ST7789 4-wire serial pins plus the decoded command/pixel outputs of the panel model.
interface st7789_rx_if #(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 240,
    parameter int RGBSIZE = 16
);
    logic                      i_cs;
    logic                      i_scl;
    logic                      i_sda;
    logic                      i_rs;
    logic                      o_cmd_valid;
    logic [7:0]                o_cmd_byte;
    logic                      o_pix_valid;
    logic [$clog2(WIDTH)-1:0]  o_pix_x;
    logic [$clog2(HEIGHT)-1:0] o_pix_y;
    logic [RGBSIZE-1:0]        o_pix_rgb;
    logic                      o_frame_start;
    logic                      o_frame_done;
    logic                      o_byte_abort;
    logic                      o_sleeping;
    logic                      o_display_on;

    modport master (
        output i_cs, i_scl, i_sda, i_rs,
        input  o_cmd_valid, o_cmd_byte, o_pix_valid, o_pix_x, o_pix_y, o_pix_rgb,
        input  o_frame_start, o_frame_done, o_byte_abort, o_sleeping, o_display_on
    );

    modport slave (
        input  i_cs, i_scl, i_sda, i_rs,
        output o_cmd_valid, o_cmd_byte, o_pix_valid, o_pix_x, o_pix_y, o_pix_rgb,
        output o_frame_start, o_frame_done, o_byte_abort, o_sleeping, o_display_on
    );
endinterface

// File: rtl/st7789_rx_spi_byte_rx.sv
// spi_byte_rx: synchronizes the asynchronous serial pins and deserializes MSB-first mode-0 bytes.
module spi_byte_rx (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_cs,
    input  logic       i_scl,
    input  logic       i_sda,
    input  logic       i_rs,
    output logic       o_byte_rdy,
    output logic [7:0] o_byte,
    output logic       o_byte_rs,
    output logic       o_byte_abort
);
    logic [1:0] r_cs_s;
    logic [1:0] r_scl_s;
    logic [1:0] r_sda_s;
    logic [1:0] r_rs_s;
    logic       r_scl_d;
    logic [6:0] r_shift;
    logic [2:0] r_cnt;
    logic       w_rise;

    // sda/rs share the scl synchronizer depth, so they stay aligned with the detected edge
    assign w_rise = r_scl_s[1] & ~r_scl_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_s       <= 2'b11;
            r_scl_s      <= 2'b00;
            r_sda_s      <= 2'b00;
            r_rs_s       <= 2'b00;
            r_scl_d      <= 1'b0;
            r_shift      <= '0;
            r_cnt        <= '0;
            o_byte_rdy   <= 1'b0;
            o_byte       <= '0;
            o_byte_rs    <= 1'b0;
            o_byte_abort <= 1'b0;
        end else begin
            r_cs_s       <= {r_cs_s[0], i_cs};
            r_scl_s      <= {r_scl_s[0], i_scl};
            r_sda_s      <= {r_sda_s[0], i_sda};
            r_rs_s       <= {r_rs_s[0], i_rs};
            r_scl_d      <= r_scl_s[1];
            o_byte_rdy   <= 1'b0;
            o_byte_abort <= 1'b0;
            if (r_cs_s[1]) begin
                r_cnt        <= '0;
                o_byte_abort <= r_cnt != 3'd0;
            end else if (w_rise) begin
                r_shift <= {r_shift[5:0], r_sda_s[1]};
                r_cnt   <= r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    o_byte     <= {r_shift, r_sda_s[1]};
                    o_byte_rs  <= r_rs_s[1];
                    o_byte_rdy <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/st7789_rx.sv
// st7789_rx: ST7789 panel model; decodes the serial command stream and turns RAMWR data
// into addressed RGB565 pixel writes inside the CASET/RASET window.
module st7789_rx
    import st7789_pkg::*;
#(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 240,
    parameter int RGBSIZE = 16
) (
    input logic        clk,
    input logic        reset,
    st7789_rx_if.slave bus
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [15:0] W16 = 16'(WIDTH);
    localparam logic [15:0] H16 = 16'(HEIGHT);

    logic               w_rdy;
    logic [7:0]         w_byte;
    logic               w_rs;
    logic               w_abort;
    logic               w_cmd;
    logic               w_dat;
    logic               w_pix;
    logic               w_last_x;
    logic               w_last_y;
    logic [15:0]        w_win_end;
    logic               w_win_ok;
    dec_state_t         r_state;
    dec_state_t         w_state_nxt;
    logic [1:0]         r_idx;
    logic               r_phase;
    logic [7:0]         r_hi;
    logic [15:0]        r_pa;
    logic [7:0]         r_pb_hi;
    logic [XW-1:0]      r_xs;
    logic [XW-1:0]      r_xe;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_ys;
    logic [YW-1:0]      r_ye;
    logic [YW-1:0]      r_y;
    logic               r_cmd_valid;
    logic [7:0]         r_cmd_byte;
    logic               r_pix_valid;
    logic [XW-1:0]      r_pix_x;
    logic [YW-1:0]      r_pix_y;
    logic [RGBSIZE-1:0] r_pix_rgb;
    logic               r_frame_start;
    logic               r_frame_done;
    logic               r_sleeping;
    logic               r_display_on;

    spi_byte_rx u_rx (
        .clk         (clk),
        .reset       (reset),
        .i_cs        (bus.i_cs),
        .i_scl       (bus.i_scl),
        .i_sda       (bus.i_sda),
        .i_rs        (bus.i_rs),
        .o_byte_rdy  (w_rdy),
        .o_byte      (w_byte),
        .o_byte_rs   (w_rs),
        .o_byte_abort(w_abort)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cmd       = w_rdy & ~w_rs;
        w_dat       = w_rdy & w_rs;
        w_pix       = w_dat && r_state == S_RAMWR && r_phase;
        w_last_x    = r_x == r_xe;
        w_last_y    = r_y == r_ye;
        w_win_end   = {r_pb_hi, w_byte};
        w_win_ok    = r_pa <= w_win_end && w_win_end < (r_state == S_CASET ? W16 : H16);
        if (w_cmd)
            w_state_nxt = w_byte == CMD_CASET ? S_CASET :
                          w_byte == CMD_RASET ? S_RASET :
                          w_byte == CMD_RAMWR ? S_RAMWR :
                          is_ctrl_cmd(w_byte) ? S_IDLE : S_SKIP;
        else if (w_dat && (r_state == S_CASET || r_state == S_RASET) && r_idx == 2'd3)
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx         <= '0;
            r_phase       <= 1'b0;
            r_hi          <= '0;
            r_pa          <= '0;
            r_pb_hi       <= '0;
            r_xs          <= '0;
            r_xe          <= XW'(WIDTH - 1);
            r_ys          <= '0;
            r_ye          <= YW'(HEIGHT - 1);
            r_x           <= '0;
            r_y           <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_byte    <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_rgb     <= '0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_sleeping    <= 1'b1;
            r_display_on  <= 1'b0;
        end else begin
            r_cmd_valid   <= w_cmd;
            r_frame_start <= w_cmd && w_byte == CMD_RAMWR;
            r_pix_valid   <= w_pix;
            r_frame_done  <= w_pix && w_last_x && w_last_y;
            if (w_cmd) begin
                // any command also drops a pending half-pixel by clearing the phase
                r_cmd_byte   <= w_byte;
                r_idx        <= '0;
                r_phase      <= 1'b0;
                r_x          <= r_xs;
                r_y          <= r_ys;
                r_sleeping   <= w_byte == CMD_SLPOUT ? 1'b0 : w_byte == CMD_SLPIN ? 1'b1 : r_sleeping;
                r_display_on <= w_byte == CMD_DISPON ? 1'b1 : w_byte == CMD_DISPOFF ? 1'b0 : r_display_on;
            end else if (w_dat) begin
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd0) r_pa[15:8] <= w_byte;
                if (r_idx == 2'd1) r_pa[7:0] <= w_byte;
                if (r_idx == 2'd2) r_pb_hi <= w_byte;
                if (r_state == S_CASET && r_idx == 2'd3 && w_win_ok) begin
                    r_xs <= r_pa[XW-1:0];
                    r_xe <= w_win_end[XW-1:0];
                end
                if (r_state == S_RASET && r_idx == 2'd3 && w_win_ok) begin
                    r_ys <= r_pa[YW-1:0];
                    r_ye <= w_win_end[YW-1:0];
                end
                if (r_state == S_RAMWR) begin
                    r_phase <= ~r_phase;
                    if (!r_phase) r_hi <= w_byte;
                    else begin
                        r_pix_x   <= r_x;
                        r_pix_y   <= r_y;
                        r_pix_rgb <= RGBSIZE'({r_hi, w_byte});
                        r_x       <= w_last_x ? r_xs : r_x + XW'(1);
                        if (w_last_x) r_y <= w_last_y ? r_ys : r_y + YW'(1);
                    end
                end
            end
        end
    end

    assign bus.o_cmd_valid   = r_cmd_valid;
    assign bus.o_cmd_byte    = r_cmd_byte;
    assign bus.o_pix_valid   = r_pix_valid;
    assign bus.o_pix_x       = r_pix_x;
    assign bus.o_pix_y       = r_pix_y;
    assign bus.o_pix_rgb     = r_pix_rgb;
    assign bus.o_frame_start = r_frame_start;
    assign bus.o_frame_done  = r_frame_done;
    assign bus.o_byte_abort  = w_abort;
    assign bus.o_sleeping    = r_sleeping;
    assign bus.o_display_on  = r_display_on;

endmodule

// File: tb/tb_st7789_rx.sv
// tb_st7789_rx: directed and randomized serial traffic into a reduced-size panel, checked against
// a window/raster model computed from the command rules.
module tb_st7789_rx;
    import st7789_pkg::*;

    localparam int W  = 20;
    localparam int H  = 10;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam logic [63:0] RST_OUTS = 64'h2;

    typedef struct packed {
        logic          done;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [15:0]   rgb;
    } pix_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    pix_t       pix_q[$];
    pix_t       exp_q[$];
    logic [7:0] cmd_q[$];
    int n_assert = 0, n_fail = 0, n_fs = 0, n_abort = 0, n_stray = 0;
    int m_xs = 0, m_xe = W - 1, m_ys = 0, m_ye = H - 1, m_k = 0;

    st7789_rx_if #(.WIDTH(W), .HEIGHT(H)) bus ();
    st7789_rx #(.WIDTH(W), .HEIGHT(H)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_cmd_valid) cmd_q.push_back(bus.o_cmd_byte);
        if (bus.o_pix_valid) pix_q.push_back(pix_t'({bus.o_frame_done, bus.o_pix_x, bus.o_pix_y, bus.o_pix_rgb}));
        else if (bus.o_frame_done) n_stray++;
        if (bus.o_frame_start) n_fs++;
        if (bus.o_byte_abort) n_abort++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] outs();
        return 64'({bus.o_cmd_valid, bus.o_cmd_byte, bus.o_pix_valid, bus.o_pix_x, bus.o_pix_y,
                    bus.o_pix_rgb, bus.o_frame_start, bus.o_frame_done, bus.o_byte_abort,
                    bus.o_sleeping, bus.o_display_on});
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic r, input int hp);
        bus.i_cs = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            bus.i_sda = b[i];
            bus.i_rs  = r;
            #hp bus.i_scl = 1'b1;
            #hp bus.i_scl = 1'b0;
        end
    endtask

    task automatic cmd(input logic [7:0] b);
        send_byte(b, 1'b0, 40);
        if (b == CMD_RAMWR) m_k = 0;
    endtask

    task automatic dat(input logic [7:0] b);
        send_byte(b, 1'b1, 20);
    endtask

    // Window commands: committed only when start <= end and end lies inside the panel.
    task automatic win(input logic [7:0] c, input int s, input int e);
        cmd(c);
        dat(8'(s >> 8)); dat(8'(s)); dat(8'(e >> 8)); dat(8'(e));
        if (s <= e && e < (c == CMD_CASET ? W : H)) begin
            if (c == CMD_CASET) begin m_xs = s; m_xe = e; end
            else begin m_ys = s; m_ye = e; end
        end
    endtask

    // Pixel k of a RAMWR stream lands at raster index k mod window area.
    task automatic pixel(input logic [15:0] rgb);
        int w, n, i;
        pix_t p;
        w = m_xe - m_xs + 1;
        n = w * (m_ye - m_ys + 1);
        i = m_k % n;
        dat(rgb[15:8]);
        dat(rgb[7:0]);
        p.done = i == n - 1;
        p.x    = XW'(m_xs + i % w);
        p.y    = YW'(m_ys + i / w);
        p.rgb  = rgb;
        exp_q.push_back(p);
        m_k++;
    endtask

    task automatic settle(input string tag, input int n_cmd, input logic [7:0] last);
        bus.i_cs = 1'b1;
        repeat (12) @(negedge clk);
        check({tag, "_ncmd"}, 64'(cmd_q.size()), 64'(n_cmd));
        if (cmd_q.size() > 0) check({tag, "_cmd"}, 64'(cmd_q[$]), 64'(last));
        check({tag, "_npix"}, 64'(pix_q.size()), 64'(exp_q.size()));
        while (pix_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_pix"}, 64'(pix_q.pop_front()), 64'(exp_q.pop_front()));
        pix_q.delete();
        exp_q.delete();
        cmd_q.delete();
    endtask

    initial begin
        int fs0, ab0;
        bus.i_cs = 1'b1; bus.i_scl = 1'b0; bus.i_sda = 1'b0; bus.i_rs = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), RST_OUTS);
        reset = 1'b0;

        cmd(CMD_SLPOUT);
        settle("slpout", 1, CMD_SLPOUT);
        check("slpout_sleeping", 64'(bus.o_sleeping), 64'(0));
        check("slpout_display", 64'(bus.o_display_on), 64'(0));

        fs0 = n_fs;
        cmd(CMD_RAMWR);
        for (int k = 0; k <= W * H; k++) pixel({8'((k % (W * H)) / W), 8'(k % W)});
        settle("frame", 1, CMD_RAMWR);
        check("frame_start_cnt", 64'(n_fs - fs0), 64'(1));

        win(CMD_CASET, 10, 12);
        win(CMD_RASET, 5, 6);
        cmd(CMD_RAMWR);
        repeat (6) pixel(16'($urandom));
        settle("window", 3, CMD_RAMWR);

        win(CMD_CASET, 320, 0);
        win(CMD_CASET, 0, W);
        win(CMD_RASET, 3, H - 1);
        cmd(8'h36); dat(8'h2A); dat(8'h00);
        cmd(CMD_RAMWR);
        repeat (4) pixel(16'($urandom));
        settle("inval", 5, CMD_RAMWR);

        ab0 = n_abort;
        bus.i_cs = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.i_sda = 1'b1;
            #40 bus.i_scl = 1'b1;
            #40 bus.i_scl = 1'b0;
        end
        bus.i_cs = 1'b1;
        #200;
        cmd(CMD_DISPON);
        settle("abort", 1, CMD_DISPON);
        check("abort_cnt", 64'(n_abort - ab0), 64'(1));
        check("abort_display", 64'(bus.o_display_on), 64'(1));

        cmd(CMD_RAMWR);
        pixel(16'($urandom));
        dat(8'hA5);
        cmd(CMD_DISPOFF);
        cmd(CMD_SLPIN);
        settle("halfpix", 3, CMD_SLPIN);
        check("halfpix_display", 64'(bus.o_display_on), 64'(0));
        check("halfpix_sleeping", 64'(bus.o_sleeping), 64'(1));

        for (int t = 0; t < 3; t++) begin
            win(CMD_CASET, int'($urandom_range(W + 2)), int'($urandom_range(W + 2)));
            win(CMD_RASET, int'($urandom_range(H + 2)), int'($urandom_range(H + 2)));
            cmd(CMD_RAMWR);
            repeat ($urandom_range(20, 1)) pixel(16'($urandom));
            settle("rand", 3, CMD_RAMWR);
        end

        cmd(CMD_DISPON);
        cmd(CMD_SLPOUT);
        cmd(CMD_RAMWR);
        repeat (3) pixel(16'($urandom));
        settle("prereset", 3, CMD_RAMWR);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid", outs(), RST_OUTS);
        reset = 1'b0;
        m_xs = 0; m_xe = W - 1; m_ys = 0; m_ye = H - 1;
        dat(8'h12); dat(8'h34); dat(8'h56); dat(8'h78);
        settle("post_reset", 0, 8'h00);
        cmd(CMD_RAMWR);
        repeat (2) pixel(16'($urandom));
        settle("rewrite", 1, CMD_RAMWR);

        check("stray_done", 64'(n_stray), 64'(0));
        check("abort_total", 64'(n_abort), 64'(1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/st7789_rx.md
Name: st7789_rx

Overview:
- Synthesizable receive end of the ST7789 4-wire serial link (cs, scl, sda, rs), i.e. a panel model.
- Deserializes bytes and decodes the command subset the console's LCD driver emits.
- Turns the RAMWR stream into addressed RGB565 pixel writes.
- Uses: loopback verification of the LCD driver, and feeding a shadow framebuffer / video capture.

Parameters:
- WIDTH, 320, panel columns.
- HEIGHT, 240, panel rows.
- RGBSIZE, 16, pixel width; only 16 (RGB565, two bytes per pixel) is supported.

Ports:
- clk  in  1  system clock; must be at least 4x scl frequency.
- reset  in  1  reset, synchronous, active-high.
- cs  in  1  chip select, active-low, asynchronous to clk.
- scl  in  1  serial clock; data sampled on rising edge (mode 0).
- sda  in  1  serial data, MSB first.
- rs  in  1  0 = command byte, 1 = data byte; sampled with the 8th bit.
- cmd_valid  out  1  one-cycle pulse per received command byte.
- cmd_byte  out  8  last command byte.
- pix_valid  out  1  one-cycle pulse per completed pixel.
- pix_x  out  $clog2(WIDTH)  pixel column.
- pix_y  out  $clog2(HEIGHT)  pixel row.
- pix_rgb  out  RGBSIZE  pixel value, high byte first on the wire.
- frame_start  out  1  pulse on RAMWR (0x2C).
- frame_done  out  1  pulse with the pixel written at (xe, ye).
- byte_abort  out  1  pulse when cs rises with 1-7 bits shifted.
- sleeping  out  1  panel sleep state.
- display_on  out  1  display enable state.

Behaviour:
- Synchronization: cs, scl, sda, rs each pass through a 2-flop synchronizer. scl rising edge = sync'd scl 0 in the previous clk cycle and 1 now.
- Shifting: on a detected scl rising edge with sync'd cs low, shift sda into an 8-bit register and increment a 3-bit bit counter.
- Byte completion: on the 8th edge, latch byte and rs; byte_rdy asserts the next clk. Decoded outputs (cmd_valid, pix_valid, frame_start, frame_done) assert the clk after byte_rdy.
- cs framing: cs high clears the bit counter. With counter != 0, the partial byte is discarded and byte_abort pulses. cs may toggle per byte or stay low across bytes; both are legal.
- Decoder FSM, states:
  - IDLE
  - CASET_P (param index 0-3)
  - RASET_P (param index 0-3)
  - RAMWR (byte phase HI/LO)
  - SKIP
- Any command byte (rs=0), from any state, pulses cmd_valid, updates cmd_byte, and transitions:
  - 0x2A -> CASET_P, idx 0
  - 0x2B -> RASET_P, idx 0
  - 0x2C -> RAMWR: x <= xs, y <= ys, phase HI, frame_start pulse
  - 0x11 -> sleeping <= 0, IDLE
  - 0x10 -> sleeping <= 1, IDLE
  - 0x29 -> display_on <= 1, IDLE
  - 0x28 -> display_on <= 0, IDLE
  - others (e.g. 0x36, 0x3A) -> SKIP; their data bytes are ignored.
- CASET/RASET parameters: big-endian 16-bit start then end. After idx 3, commit the window only if start <= end and end < WIDTH (resp. HEIGHT); otherwise keep the old window. Then go to IDLE. Extra data bytes in IDLE are ignored.
- RAMWR pixel assembly:
  - HI byte -> pix_rgb[15:8] held in a staging register.
  - LO byte completes the pixel: pix_valid pulses with the current x, y.
- RAMWR addressing after each pixel:
  - x == xe: x <= xs, then y <= (y == ye) ? ys : y+1.
  - x == xe and y == ye: frame_done pulses in the same cycle as that pix_valid; the stream continues wrapping at (xs, ys).
- A command arriving with phase LO pending drops the half-pixel (no pix_valid).
- Reset values:
  - All pulse outputs 0; cmd_byte 0; pix_x, pix_y, pix_rgb 0.
  - sleeping 1, display_on 0.
  - Window xs=0, xe=WIDTH-1, ys=0, ye=HEIGHT-1.
  - FSM IDLE, bit counter 0, synchronizer flops 1 for cs and 0 for the others.
- Reset mid-byte or mid-frame: everything returns to the above immediately; no pulses in the reset cycle.

Decomposition:
- Package st7789_pkg:
  - Command localparams CMD_SLPIN 8'h10, CMD_SLPOUT 8'h11, CMD_DISPOFF 8'h28, CMD_DISPON 8'h29, CMD_CASET 8'h2A, CMD_RASET 8'h2B, CMD_RAMWR 8'h2C.
  - Decoder state enum.
- Sub-module spi_byte_rx: synchronizers, edge detect, shift register, bit counter. Outputs byte_rdy, byte, byte_rs, byte_abort.
- st7789_rx instantiates spi_byte_rx and holds the decoder FSM and address counters.

Test Plan:
- SLPOUT: send 0x11 (rs=0), scl = clk/8 -> one cmd_valid, cmd_byte=0x11, sleeping 1->0; display_on stays 0.
- Full frame: 0x2C then 320*240*2 data bytes, each pixel = {y[7:0], x[7:0]} -> frame_start once; 76800 pix_valid in raster order with matching pix_rgb; frame_done coincident with (319, 239); next pixel lands at (0, 0).
- Windowed write: CASET 00 0A 00 0C, RASET 00 05 00 06, RAMWR + 12 bytes -> pixels at (10,5) (11,5) (12,5) (10,6) (11,6) (12,6); frame_done on the 6th.
- Invalid window: CASET 01 40 00 00 (start 320 > end) -> window unchanged; subsequent RAMWR starts at the previous xs.
- Abort: raise cs after 5 bits, then send full byte 0x29 -> byte_abort pulses once; display_on 0->1 with no spurious byte.
- Reset mid-frame: assert reset after 3 pixels of RAMWR -> all outputs at reset values next cycle; following data bytes are ignored until a new 0x2C.
